// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
// Turns one register-level I2C request (register write or register read) into
// the byte-level command stream of the I2C master core. It gathers the slave
// ACK/NACK status and the read data, and returns one response per request.
// Every command sent to the core is guarded by a watchdog.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_rw                     0 = register write, 1 = register read
//   req_dev_addr               7-bit slave address
//   req_reg_addr, req_wdata    register address and write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata                  read data (0x00 for writes and failures)
//   rsp_nack                   slave NACKed a written byte
//   rsp_timeout                core did not finish a command in time
//   core_cmd/_valid/_ready     command to the byte core (0=START 1=WRITE
//                              2=READ_NACK 3=STOP 4=RESTART)
//   core_wbyte                 byte for WRITE
//   core_done, core_ack,       completion pulse with write ACK status and
//   core_rbyte                 read byte
//   core_abort                 one-cycle pulse: core must return bus to idle
module i2c_txn_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic [2:0] core_cmd,
  output logic       core_cmd_valid,
  input  logic       core_cmd_ready,
  output logic [7:0] core_wbyte,
  input  logic       core_done,
  input  logic       core_ack,
  input  logic [7:0] core_rbyte,
  output logic       core_abort
);

  typedef enum logic [3:0] {
    IDLE, S_START, S_DEVW, S_REG, S_DATA, S_RESTART, S_DEVR, S_READ, S_STOP, S_RESP
  } state_t;

  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WRITE   = 3'd1;
  localparam logic [2:0] CMD_READ    = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  // Watchdog value at which a WAIT without core_done gives up.
  localparam logic [15:0] WD_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_q, wd_d;

  state_t      succ;       // next state when the current command succeeds
  logic        wd_expire;

  assign wd_expire   = (TIMEOUT_CYCLES != 16'd0) && (wd_q == WD_LAST);
  assign rsp_rdata   = rdata_q;
  assign rsp_nack    = nack_q;
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= PH_ISSUE;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    rw_d           = rw_q;
    dev_d          = dev_q;
    reg_d          = reg_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    nack_d         = nack_q;
    timeout_d      = timeout_q;
    wd_d           = wd_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    core_cmd_valid = 1'b0;
    core_cmd       = CMD_STOP;
    core_wbyte     = 8'h00;
    core_abort     = 1'b0;
    succ           = S_RESP;

    // Command and byte presented by each command state, and its successor.
    case (state_q)
      S_START:   begin core_cmd = CMD_START;   succ = S_DEVW; end
      S_DEVW:    begin core_cmd = CMD_WRITE;   core_wbyte = {dev_q, 1'b0}; succ = S_REG; end
      S_REG:     begin
        core_cmd   = CMD_WRITE;
        core_wbyte = reg_q;
        succ       = rw_q ? S_RESTART : S_DATA;
      end
      S_DATA:    begin core_cmd = CMD_WRITE;   core_wbyte = wdata_q; succ = S_STOP; end
      S_RESTART: begin core_cmd = CMD_RESTART; succ = S_DEVR; end
      S_DEVR:    begin core_cmd = CMD_WRITE;   core_wbyte = {dev_q, 1'b1}; succ = S_READ; end
      S_READ:    begin core_cmd = CMD_READ;    succ = S_STOP; end
      S_STOP:    begin core_cmd = CMD_STOP;    succ = S_RESP; end
      default:   ;
    endcase

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rw_d    = req_rw;
          dev_d   = req_dev_addr;
          reg_d   = req_reg_addr;
          wdata_d = req_wdata;
          state_d = S_START;
          phase_d = PH_ISSUE;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rdata_d   = 8'h00;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        if (phase_q == PH_ISSUE) begin
          // Watchdog is frozen while the core is not ready; core_done ignored.
          core_cmd_valid = 1'b1;
          if (core_cmd_ready) begin
            phase_d = PH_WAIT;
            wd_d    = 16'd0;
          end
        end else if (core_done) begin
          // core_done beats a watchdog expiry in the same cycle.
          phase_d = PH_ISSUE;
          if (state_q == S_READ) begin
            rdata_d = core_rbyte;
          end
          if ((core_cmd == CMD_WRITE) && !core_ack) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = succ;
          end
        end else if (wd_expire) begin
          // Abandon the bus without STOP; timeout overrides any earlier NACK.
          core_abort = 1'b1;
          timeout_d  = 1'b1;
          nack_d     = 1'b0;
          rdata_d    = 8'h00;
          phase_d    = PH_ISSUE;
          state_d    = S_RESP;
        end else begin
          wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer (TIMEOUT_CYCLES = 8). The main process issues
// directed requests and queues the expected core commands and responses.
// A single monitor process models the byte core, which pulses done two cycles
// after a handshake by default. The same process pops and compares the
// queues whenever the DUT hands over a command or a response.
module tb_i2c_txn_sequencer;

  localparam logic [2:0] C_START = 3'd0, C_WRITE = 3'd1, C_READ = 3'd2,
                         C_STOP = 3'd3, C_RESTART = 3'd4;

  typedef struct packed {logic [2:0] cmd; logic [7:0] b;} cmd_t;
  typedef struct packed {logic [7:0] rdata; logic nack; logic to;} rsp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_nack, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [2:0] core_cmd;
  logic       core_cmd_valid, core_cmd_ready, core_done, core_ack, core_abort;
  logic [7:0] core_wbyte, core_rbyte;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .core_cmd(core_cmd), .core_cmd_valid(core_cmd_valid), .core_cmd_ready(core_cmd_ready),
    .core_wbyte(core_wbyte), .core_done(core_done), .core_ack(core_ack),
    .core_rbyte(core_rbyte), .core_abort(core_abort)
  );

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  // Knobs written by the main process, read by the monitor.
  logic       k_nack_en = 0, k_nd_en = 0, k_stall_en = 0, k_exp_abort = 0;
  logic       k_chk_lat = 0, k_chk_idle = 0, fin = 0;
  logic [7:0] k_nack_byte = 0, k_nd_byte = 0, k_stall_byte = 0, k_rbyte = 0;
  logic [2:0] k_nd_cmd = 0;
  int         k_done_dly = 2;
  int         hang_cnt = 0;

  // Monitor-owned state.
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, pend = 0, hs_cyc = 0, acc_cyc = 0, stall_cnt = 0;
  int   abort_cnt = 0, hang_seen = 0, rsp_no = 0;
  logic pend_ack = 1'b1, prev_rv = 1'b0, after_rsp = 1'b0, fin_done = 1'b0;
  logic [7:0] pend_rbyte = 8'h00;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte-core model plus scoreboard/monitor.
  initial begin
    core_cmd_ready = 1'b1;
    core_done      = 1'b0;
    core_ack       = 1'b0;
    core_rbyte     = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done  = 1'b1;
          core_ack   = pend_ack;
          core_rbyte = pend_rbyte;
        end
      end
      if (!k_stall_en) stall_cnt = 0;
      core_cmd_ready = 1'b1;
      if (k_stall_en && core_cmd_valid && core_cmd == C_WRITE &&
          core_wbyte == k_stall_byte && stall_cnt < 5) begin
        core_cmd_ready = 1'b0;
        stall_cnt++;
      end

      @(negedge clk);
      if (!reset_n) begin
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_valid", core_cmd_valid, 0);
        chk("rst_abort", core_abort, 0);
        chk("rst_core_cmd", core_cmd, C_STOP);
        chk("rst_wbyte", core_wbyte, 0);
        pend      = 0;
        after_rsp = 1'b0;
        prev_rv   = 1'b0;
      end else begin
        if (k_chk_idle) begin
          chk("idle_req_ready", req_ready, 1);
          chk("idle_no_rsp", rsp_valid, 0);
        end
        if (after_rsp) begin
          chk("req_ready_after_rsp", req_ready, 1);
          after_rsp = 1'b0;
        end
        if (req_valid && req_ready) acc_cyc = cyc;

        if (!core_cmd_ready) begin
          chk("stall_cmd_valid", core_cmd_valid, 1);
          chk("stall_cmd", core_cmd, C_WRITE);
          chk("stall_wbyte", core_wbyte, k_stall_byte);
        end

        if (core_cmd_valid && core_cmd_ready) begin
          hs_cyc = cyc;
          if (exp_cmd.size() == 0) begin
            chk("cmd_unexpected", {5'd0, core_cmd}, 8'hFF);
          end else begin
            cmd_t e;
            e = exp_cmd.pop_front();
            chk("cmd", core_cmd, e.cmd);
            if (e.cmd == C_WRITE) chk("cmd_wbyte", core_wbyte, e.b);
          end
          if (k_nd_en && core_cmd == k_nd_cmd &&
              (core_cmd != C_WRITE || core_wbyte == k_nd_byte)) pend = 0;
          else pend = k_done_dly;
          pend_ack   = !(k_nack_en && core_cmd == C_WRITE && core_wbyte == k_nack_byte);
          pend_rbyte = k_rbyte;
        end

        if (core_abort) begin
          abort_cnt++;
          chk("abort_expected", k_exp_abort, 1);
          chk("abort_delay", cyc - hs_cyc, 8);
        end

        if (rsp_valid && !prev_rv && k_chk_lat) chk("write_latency", cyc - acc_cyc, 16);

        if (rsp_valid && exp_rsp.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else if (rsp_valid && !rsp_ready) begin
          chk("hold_rdata", rsp_rdata, exp_rsp[0].rdata);
          chk("hold_nack", rsp_nack, exp_rsp[0].nack);
          chk("hold_timeout", rsp_timeout, exp_rsp[0].to);
          chk("hold_req_ready", req_ready, 0);
        end else if (rsp_valid && rsp_ready) begin
          rsp_t r;
          r = exp_rsp.pop_front();
          rsp_no++;
          $display("rsp %0d: rdata=0x%02h nack=%0b timeout=%0b (expected 0x%02h %0b %0b)",
                   rsp_no, rsp_rdata, rsp_nack, rsp_timeout, r.rdata, r.nack, r.to);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_nack", rsp_nack, r.nack);
          chk("rsp_timeout", rsp_timeout, r.to);
          after_rsp = 1'b1;
        end
        prev_rv = rsp_valid;
      end

      if (hang_cnt != hang_seen) begin
        chk("wait_bound", hang_cnt, hang_seen);
        hang_seen = hang_cnt;
      end
      if (fin && !fin_done) begin
        chk("cmds_left", exp_cmd.size(), 0);
        chk("rsps_left", exp_rsp.size(), 0);
        chk("abort_total", abort_cnt, 1);
        fin_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void pc(input logic [2:0] c, input logic [7:0] b);
    cmd_t x;
    x.cmd = c;
    x.b   = b;
    exp_cmd.push_back(x);
  endfunction

  function automatic void pr(input logic [7:0] d, input logic n, input logic t);
    rsp_t x;
    x.rdata = d;
    x.nack  = n;
    x.to    = t;
    exp_rsp.push_back(x);
  endfunction

  task automatic defaults();
    k_nack_en = 0; k_nd_en = 0; k_stall_en = 0; k_exp_abort = 0;
    k_chk_lat = 0; k_chk_idle = 0; k_done_dly = 2; k_rbyte = 8'h00;
    rsp_ready = 1'b1;
  endtask

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                      input logic [7:0] wd);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    $display("req: rw=%0b dev=0x%02h reg=0x%02h wdata=0x%02h", rw, dev, ra, wd);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    if (!got) hang_cnt++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_cmd.size() == 0 && exp_rsp.size() == 0 && req_ready && !core_cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      hang_cnt++;
      exp_cmd.delete();
      exp_rsp.delete();
    end
    @(posedge clk);
    #1;
    defaults();
  endtask

  function automatic void exp_write(input logic [6:0] dev, input logic [7:0] ra,
                                    input logic [7:0] wd);
    pc(C_START, 0); pc(C_WRITE, {dev, 1'b0}); pc(C_WRITE, ra); pc(C_WRITE, wd); pc(C_STOP, 0);
  endfunction

  function automatic void exp_read(input logic [6:0] dev, input logic [7:0] ra);
    pc(C_START, 0); pc(C_WRITE, {dev, 1'b0}); pc(C_WRITE, ra); pc(C_RESTART, 0);
    pc(C_WRITE, {dev, 1'b1}); pc(C_READ, 0); pc(C_STOP, 0);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    req_valid = 0; req_rw = 0; req_dev_addr = 0; req_reg_addr = 0; req_wdata = 0;
    defaults();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Plain write, with accept-to-response latency check.
    k_chk_lat = 1;
    exp_write(7'h50, 8'h10, 8'hA5); pr(8'h00, 0, 0);
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_idle();

    // Plain read.
    k_rbyte = 8'h5A;
    exp_read(7'h50, 8'h22); pr(8'h5A, 0, 0);
    send(1, 7'h50, 8'h22, 8'hFF);
    wait_idle();

    // NACK on the address byte of a write: straight to STOP.
    k_nack_en = 1; k_nack_byte = 8'hA0;
    pc(C_START, 0); pc(C_WRITE, 8'hA0); pc(C_STOP, 0); pr(8'h00, 1, 0);
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_idle();

    // NACK on the read-direction address byte.
    k_nack_en = 1; k_nack_byte = 8'h79; k_rbyte = 8'h33;
    pc(C_START, 0); pc(C_WRITE, 8'h78); pc(C_WRITE, 8'h07); pc(C_RESTART, 0);
    pc(C_WRITE, 8'h79); pc(C_STOP, 0); pr(8'h00, 1, 0);
    send(1, 7'h3C, 8'h07, 8'h00);
    wait_idle();

    // core_done lands on the watchdog expiry cycle: done must win.
    k_done_dly = 8;
    exp_write(7'h50, 8'h10, 8'hA5); pr(8'h00, 0, 0);
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_idle();

    // START never completes: abort, timeout, no STOP.
    k_nd_en = 1; k_nd_cmd = C_START; k_exp_abort = 1;
    pc(C_START, 0); pr(8'h00, 0, 1);
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_idle();

    // Core stalls the register byte for 5 cycles; response held 3 cycles.
    k_stall_en = 1; k_stall_byte = 8'h10; k_rbyte = 8'hC3; rsp_ready = 1'b0;
    exp_read(7'h50, 8'h10); pr(8'hC3, 0, 0);
    send(1, 7'h50, 8'h10, 8'h00);
    begin
      logic got;
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1'b1; break; end
      end
      if (!got) hang_cnt++;
    end
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Reset while waiting on the register byte: no STOP, no response.
    k_nd_en = 1; k_nd_cmd = C_WRITE; k_nd_byte = 8'h10;
    pc(C_START, 0); pc(C_WRITE, 8'hA0); pc(C_WRITE, 8'h10);
    send(0, 7'h50, 8'h10, 8'hA5);
    begin
      logic got;
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (exp_cmd.size() == 0) begin got = 1'b1; break; end
      end
      if (!got) hang_cnt++;
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    k_nd_en = 0;
    k_chk_idle = 1;
    repeat (6) @(posedge clk);
    #1 k_chk_idle = 0;

    // Recovery: write with all-ones address fields and zero data.
    exp_write(7'h7F, 8'hFF, 8'h00); pr(8'h00, 0, 0);
    send(0, 7'h7F, 8'hFF, 8'h00);
    wait_idle();

    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout, required completion");
    $fatal(1, "time limit");
  end

endmodule
